// File: rtl/regfile_sched_if.sv
// regfile_sched_if: neighbor/config handshakes, register-file controls and FU launch/status
// signals of the operand sequencer. master = scheduler side, slave = environment side.
interface regfile_sched_if #(parameter int CNT_W = 8);
  logic n1_vld, n1_rdy, n2_vld, n2_rdy, cfg_vld, cfg_rdy;
  logic rf_wen1, rf_wen2, rf_wen3, rf_wr_ack1, rf_wr_ack2, rf_wr_ack3;
  logic rf_ren, rf_r_data_vld, fu_start, fu_done, busy, timeout_err;
  logic [CNT_W-1:0] fire_count;
  modport master (
    input  n1_vld, n2_vld, cfg_vld, rf_wr_ack1, rf_wr_ack2, rf_wr_ack3, rf_r_data_vld, fu_done,
    output n1_rdy, n2_rdy, cfg_rdy, rf_wen1, rf_wen2, rf_wen3, rf_ren, fu_start, busy,
           fire_count, timeout_err
  );
  modport slave (
    output n1_vld, n2_vld, cfg_vld, rf_wr_ack1, rf_wr_ack2, rf_wr_ack3, rf_r_data_vld, fu_done,
    input  n1_rdy, n2_rdy, cfg_rdy, rf_wen1, rf_wen2, rf_wen3, rf_ren, fu_start, busy,
           fire_count, timeout_err
  );
endinterface

// File: rtl/regfile_sched.sv
// regfile_sched: fills the operand register file, fires the vector FU, waits for done/timeout.
// Define REGFILE_SCHED_CFG_STICKY_EN to keep the config word loaded across successful firings.
module regfile_sched #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic reset,
  regfile_sched_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
`ifdef REGFILE_SCHED_CFG_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  typedef enum logic [1:0] {FILL, FIRE, EXEC} state_t;
  state_t st, st_n;
  logic [2:0] ld, ld_n, pend, pend_n, vld, ack, rdy, wen;
  logic [TW-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] fc, fc_n;
  logic terr, terr_n;
  assign vld = {bus.cfg_vld, bus.n2_vld, bus.n1_vld};
  assign ack = {bus.rf_wr_ack3, bus.rf_wr_ack2, bus.rf_wr_ack1};
  // rdy is gated by reset so nothing handshakes while the block is held in reset
  assign rdy = {3{st == FILL && reset}} & ~ld & ~pend;
  assign wen = vld & rdy;
  assign {bus.cfg_rdy, bus.n2_rdy, bus.n1_rdy} = rdy;
  assign {bus.rf_wen3, bus.rf_wen2, bus.rf_wen1} = wen;
  assign bus.rf_ren = st == FIRE || st == EXEC;
  assign bus.fu_start = st == FIRE;
  assign bus.busy = st != FILL;
  assign bus.fire_count = fc;
  assign bus.timeout_err = terr;
  always_comb begin
    st_n = st;
    ld_n = ld | (ack & pend);
    pend_n = (pend & ~ack) | wen;
    cnt_n = cnt;
    fc_n = fc;
    terr_n = terr;
    if (st == FILL) st_n = (&ld_n && !(|pend_n)) ? FIRE : FILL;
    else if (st == FIRE) begin
      st_n = EXEC;
      cnt_n = '0;
    end else if (bus.fu_done) begin
      st_n = FILL;
      fc_n = fc + 1'b1;
      ld_n = {ld[2] & STICKY, 2'b00};
    end else if (cnt == TW'(TIMEOUT_CYC - 1)) begin
      st_n = FILL;
      terr_n = 1'b1;
      ld_n = '0;
    end else cnt_n = cnt + 1'b1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= FILL;
      ld <= '0;
      pend <= '0;
      cnt <= '0;
      fc <= '0;
      terr <= 1'b0;
    end else begin
      st <= st_n;
      ld <= ld_n;
      pend <= pend_n;
      cnt <= cnt_n;
      fc <= fc_n;
      terr <= terr_n;
    end
  end
  a_rdata_vld: assert property (@(posedge clk) disable iff (!reset)
    (st != FILL) |-> (bus.rf_r_data_vld == bus.rf_ren));
  a_no_wr_in_rd: assert property (@(posedge clk) disable iff (!reset) bus.rf_ren |-> (wen == 3'b000));
endmodule

// File: tb/tb_regfile_sched.sv
// tb_regfile_sched: directed scenario tasks for regfile_sched with TIMEOUT_CYC=4, CNT_W=8
module tb_regfile_sched;
`ifdef REGFILE_SCHED_CFG_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  logic clk, reset;
  int n_cmp, n_bad;
  regfile_sched_if #(.CNT_W(8)) bus ();
  regfile_sched #(.TIMEOUT_CYC(4), .CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus.master));
  assign bus.rf_r_data_vld = bus.rf_ren;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic idle;
    {bus.n1_vld, bus.n2_vld, bus.cfg_vld} = 3'b000;
    {bus.rf_wr_ack1, bus.rf_wr_ack2, bus.rf_wr_ack3} = 3'b000;
    bus.fu_done = 1'b0;
  endtask
  task automatic do_reset;
    idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask
  // full transfer + fire; fu_done asserted dly EXEC cycles after FIRE; ends in the next FILL cycle
  task automatic fire_once(input int dly);
    {bus.n1_vld, bus.n2_vld, bus.cfg_vld} = 3'b111;
    tick();
    {bus.n1_vld, bus.n2_vld, bus.cfg_vld} = 3'b000;
    {bus.rf_wr_ack1, bus.rf_wr_ack2, bus.rf_wr_ack3} = 3'b111;
    tick();
    {bus.rf_wr_ack1, bus.rf_wr_ack2, bus.rf_wr_ack3} = 3'b000;
    repeat (dly) tick();
    bus.fu_done = 1'b1;
    tick();
    bus.fu_done = 1'b0;
  endtask
  task automatic test_reset;
    idle();
    reset = 1'b1;
    #3 reset = 1'b0;
    {bus.n1_vld, bus.n2_vld, bus.cfg_vld} = 3'b111;
    #1;
    n_cmp++;
    if ({bus.n1_rdy, bus.n2_rdy, bus.cfg_rdy, bus.rf_wen1, bus.rf_wen2, bus.rf_wen3,
         bus.rf_ren, bus.fu_start, bus.busy, bus.timeout_err} !== 10'b0) begin
      n_bad++;
      $display("FAIL reset_outs got=%b exp=0", {bus.n1_rdy, bus.n2_rdy, bus.cfg_rdy, bus.rf_wen1,
               bus.rf_wen2, bus.rf_wen3, bus.rf_ren, bus.fu_start, bus.busy, bus.timeout_err});
    end
    tick();
    n_cmp++;
    if (bus.fire_count !== 8'd0) begin n_bad++; $display("FAIL reset_fc got=%0d exp=0", bus.fire_count); end
    idle();
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.n1_rdy, bus.n2_rdy, bus.cfg_rdy, bus.busy} !== 4'b1110) begin
      n_bad++;
      $display("FAIL reset_release got=%b exp=1110", {bus.n1_rdy, bus.n2_rdy, bus.cfg_rdy, bus.busy});
    end
  endtask
  task automatic test_basic_fire;
    int ren_n, st_n;
    ren_n = 0;
    st_n = 0;
    do_reset();
    {bus.n1_vld, bus.n2_vld, bus.cfg_vld} = 3'b111;
    #1;
    n_cmp++;
    if ({bus.rf_wen1, bus.rf_wen2, bus.rf_wen3} !== 3'b111) begin
      n_bad++;
      $display("FAIL basic_wen got=%b exp=111", {bus.rf_wen1, bus.rf_wen2, bus.rf_wen3});
    end
    tick();
    {bus.n1_vld, bus.n2_vld, bus.cfg_vld} = 3'b000;
    {bus.rf_wr_ack1, bus.rf_wr_ack2, bus.rf_wr_ack3} = 3'b111;
    #1;
    n_cmp++;
    if ({bus.n1_rdy, bus.n2_rdy, bus.cfg_rdy, bus.busy} !== 4'b0000) begin
      n_bad++;
      $display("FAIL basic_pend got=%b exp=0000", {bus.n1_rdy, bus.n2_rdy, bus.cfg_rdy, bus.busy});
    end
    tick();
    {bus.rf_wr_ack1, bus.rf_wr_ack2, bus.rf_wr_ack3} = 3'b000;
    for (int i = 0; i < 4; i++) begin
      bus.fu_done = (i == 3);
      #1;
      ren_n += int'(bus.rf_ren);
      st_n += int'(bus.fu_start);
      tick();
    end
    bus.fu_done = 1'b0;
    #1;
    n_cmp++;
    if (ren_n !== 4) begin n_bad++; $display("FAIL basic_ren_cycles got=%0d exp=4", ren_n); end
    n_cmp++;
    if (st_n !== 1) begin n_bad++; $display("FAIL basic_start_pulses got=%0d exp=1", st_n); end
    n_cmp++;
    if (bus.fire_count !== 8'd1) begin n_bad++; $display("FAIL basic_fc got=%0d exp=1", bus.fire_count); end
    n_cmp++;
    if ({bus.n1_rdy, bus.n2_rdy, bus.busy, bus.rf_ren} !== 4'b1100) begin
      n_bad++;
      $display("FAIL basic_refill got=%b exp=1100", {bus.n1_rdy, bus.n2_rdy, bus.busy, bus.rf_ren});
    end
    n_cmp++;
    if (bus.cfg_rdy !== !STICKY) begin n_bad++; $display("FAIL basic_cfg_rdy got=%b exp=%b", bus.cfg_rdy, !STICKY); end
  endtask
  task automatic test_staggered;
    do_reset();
    bus.n1_vld = 1'b1;
    #1;
    n_cmp++;
    if ({bus.rf_wen1, bus.rf_wen2, bus.rf_wen3} !== 3'b100) begin
      n_bad++;
      $display("FAIL stag_wen1 got=%b exp=100", {bus.rf_wen1, bus.rf_wen2, bus.rf_wen3});
    end
    tick();
    bus.n1_vld = 1'b0;
    bus.rf_wr_ack1 = 1'b1;
    tick();
    bus.rf_wr_ack1 = 1'b0;
    bus.n1_vld = 1'b1;
    #1;
    n_cmp++;
    if ({bus.n1_rdy, bus.n2_rdy, bus.cfg_rdy, bus.rf_wen1} !== 4'b0110) begin
      n_bad++;
      $display("FAIL stag_ld1 got=%b exp=0110", {bus.n1_rdy, bus.n2_rdy, bus.cfg_rdy, bus.rf_wen1});
    end
    bus.n1_vld = 1'b0;
    repeat (3) tick();
    bus.cfg_vld = 1'b1;
    tick();
    bus.cfg_vld = 1'b0;
    bus.rf_wr_ack3 = 1'b1;
    tick();
    bus.rf_wr_ack3 = 1'b0;
    #1;
    n_cmp++;
    if ({bus.n1_rdy, bus.n2_rdy, bus.cfg_rdy, bus.busy} !== 4'b0100) begin
      n_bad++;
      $display("FAIL stag_ld3 got=%b exp=0100", {bus.n1_rdy, bus.n2_rdy, bus.cfg_rdy, bus.busy});
    end
    repeat (3) tick();
    bus.n2_vld = 1'b1;
    tick();
    bus.n2_vld = 1'b0;
    bus.rf_wr_ack2 = 1'b1;
    #1;
    n_cmp++;
    if ({bus.busy, bus.fu_start} !== 2'b00) begin
      n_bad++;
      $display("FAIL stag_ack_cycle got=%b exp=00", {bus.busy, bus.fu_start});
    end
    tick();
    bus.rf_wr_ack2 = 1'b0;
    #1;
    n_cmp++;
    if ({bus.fu_start, bus.rf_ren} !== 2'b11) begin
      n_bad++;
      $display("FAIL stag_fire got=%b exp=11", {bus.fu_start, bus.rf_ren});
    end
    repeat (2) tick();
    bus.fu_done = 1'b1;
    tick();
    bus.fu_done = 1'b0;
    #1;
    n_cmp++;
    if (bus.fire_count !== 8'd1) begin n_bad++; $display("FAIL stag_fc got=%0d exp=1", bus.fire_count); end
  endtask
  task automatic test_timeout;
    do_reset();
    {bus.n1_vld, bus.n2_vld, bus.cfg_vld} = 3'b111;
    tick();
    {bus.n1_vld, bus.n2_vld, bus.cfg_vld} = 3'b000;
    {bus.rf_wr_ack1, bus.rf_wr_ack2, bus.rf_wr_ack3} = 3'b111;
    tick();
    {bus.rf_wr_ack1, bus.rf_wr_ack2, bus.rf_wr_ack3} = 3'b000;
    repeat (4) tick();
    #1;
    n_cmp++;
    if ({bus.busy, bus.timeout_err} !== 2'b10) begin
      n_bad++;
      $display("FAIL to_4th_exec got=%b exp=10", {bus.busy, bus.timeout_err});
    end
    tick();
    #1;
    n_cmp++;
    if ({bus.timeout_err, bus.busy, bus.n1_rdy, bus.n2_rdy, bus.cfg_rdy} !== 5'b10111) begin
      n_bad++;
      $display("FAIL to_fill got=%b exp=10111",
               {bus.timeout_err, bus.busy, bus.n1_rdy, bus.n2_rdy, bus.cfg_rdy});
    end
    n_cmp++;
    if (bus.fire_count !== 8'd0) begin n_bad++; $display("FAIL to_fc got=%0d exp=0", bus.fire_count); end
    fire_once(3);
    #1;
    n_cmp++;
    if ({bus.timeout_err, bus.fire_count} !== {1'b1, 8'd1}) begin
      n_bad++;
      $display("FAIL to_sticky_err got=%b/%0d exp=1/1", bus.timeout_err, bus.fire_count);
    end
  endtask
  task automatic test_tie;
    do_reset();
    {bus.n1_vld, bus.n2_vld, bus.cfg_vld} = 3'b111;
    tick();
    {bus.n1_vld, bus.n2_vld, bus.cfg_vld} = 3'b000;
    {bus.rf_wr_ack1, bus.rf_wr_ack2, bus.rf_wr_ack3} = 3'b111;
    tick();
    {bus.rf_wr_ack1, bus.rf_wr_ack2, bus.rf_wr_ack3} = 3'b000;
    bus.fu_done = 1'b1;
    tick();
    bus.fu_done = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy, bus.fire_count} !== {1'b1, 8'd0}) begin
      n_bad++;
      $display("FAIL tie_done_in_fire got=%b/%0d exp=1/0", bus.busy, bus.fire_count);
    end
    repeat (3) tick();
    bus.fu_done = 1'b1;
    tick();
    bus.fu_done = 1'b0;
    #1;
    n_cmp++;
    if ({bus.fire_count, bus.timeout_err, bus.busy} !== {8'd1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL tie got fc=%0d err=%b busy=%b exp fc=1 err=0 busy=0",
               bus.fire_count, bus.timeout_err, bus.busy);
    end
  endtask
  task automatic test_reset_mid_exec;
    do_reset();
    repeat (3) fire_once(2);
    #1;
    n_cmp++;
    if (bus.fire_count !== 8'd3) begin n_bad++; $display("FAIL rst_pre_fc got=%0d exp=3", bus.fire_count); end
    {bus.n1_vld, bus.n2_vld, bus.cfg_vld} = 3'b111;
    tick();
    {bus.n1_vld, bus.n2_vld, bus.cfg_vld} = 3'b000;
    {bus.rf_wr_ack1, bus.rf_wr_ack2, bus.rf_wr_ack3} = 3'b111;
    tick();
    {bus.rf_wr_ack1, bus.rf_wr_ack2, bus.rf_wr_ack3} = 3'b000;
    tick();
    #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.n1_rdy, bus.n2_rdy, bus.cfg_rdy, bus.rf_ren, bus.fu_start, bus.busy,
         bus.timeout_err, bus.fire_count} !== 15'b0) begin
      n_bad++;
      $display("FAIL rst_async got=%b exp=0", {bus.n1_rdy, bus.n2_rdy, bus.cfg_rdy, bus.rf_ren,
               bus.fu_start, bus.busy, bus.timeout_err, bus.fire_count});
    end
    tick();
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.busy, bus.n1_rdy, bus.fire_count} !== {1'b0, 1'b1, 8'd0}) begin
      n_bad++;
      $display("FAIL rst_release got=%b/%b/%0d exp=0/1/0", bus.busy, bus.n1_rdy, bus.fire_count);
    end
    bus.n1_vld = 1'b1;
    tick();
    bus.n1_vld = 1'b0;
    reset = 1'b0;
    #1 reset = 1'b1;
    bus.rf_wr_ack1 = 1'b1;
    tick();
    bus.rf_wr_ack1 = 1'b0;
    #1;
    n_cmp++;
    if (bus.n1_rdy !== 1'b1) begin n_bad++; $display("FAIL rst_late_ack n1_rdy got=%b exp=1", bus.n1_rdy); end
  endtask
  task automatic test_sticky;
    do_reset();
    repeat (255) fire_once(1);
    #1;
    n_cmp++;
    if (bus.fire_count !== 8'd255) begin n_bad++; $display("FAIL sticky_fc255 got=%0d exp=255", bus.fire_count); end
    n_cmp++;
    if (bus.cfg_rdy !== !STICKY) begin n_bad++; $display("FAIL sticky_cfg_rdy got=%b exp=%b", bus.cfg_rdy, !STICKY); end
    {bus.n1_vld, bus.n2_vld} = 2'b11;
    tick();
    {bus.n1_vld, bus.n2_vld} = 2'b00;
    {bus.rf_wr_ack1, bus.rf_wr_ack2} = 2'b11;
    tick();
    {bus.rf_wr_ack1, bus.rf_wr_ack2} = 2'b00;
    #1;
    n_cmp++;
    if (bus.fu_start !== STICKY) begin n_bad++; $display("FAIL sticky_fire_nocfg got=%b exp=%b", bus.fu_start, STICKY); end
    if (!bus.fu_start) begin
      bus.cfg_vld = 1'b1;
      tick();
      bus.cfg_vld = 1'b0;
      bus.rf_wr_ack3 = 1'b1;
      tick();
      bus.rf_wr_ack3 = 1'b0;
      #1;
      n_cmp++;
      if (bus.fu_start !== 1'b1) begin n_bad++; $display("FAIL sticky_fire_cfg got=%b exp=1", bus.fu_start); end
    end
    tick();
    bus.fu_done = 1'b1;
    tick();
    bus.fu_done = 1'b0;
    #1;
    n_cmp++;
    if (bus.fire_count !== 8'd0) begin n_bad++; $display("FAIL sticky_wrap got=%0d exp=0", bus.fire_count); end
    n_cmp++;
    if ({bus.cfg_rdy, bus.n1_rdy} !== {!STICKY, 1'b1}) begin
      n_bad++;
      $display("FAIL sticky_after got=%b exp=%b", {bus.cfg_rdy, bus.n1_rdy}, {!STICKY, 1'b1});
    end
  endtask
  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic_fire();
    test_staggered();
    test_timeout();
    test_tie();
    test_reset_mid_exec();
    test_sticky();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_sched.md
# regfile_sched

Sequencing controller for the tile's operand register file. It accepts operand-vector transfers from the two CGRA network neighbors and a config word from the config network, and drives the register file's write enables. Once all three are loaded, it switches the register file to read mode and launches the vector FU. It holds read mode until the FU reports completion or a timeout expires, then reopens the register file for the next operand set.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 255: maximum number of EXEC cycles to wait for `fu_done`.
- `CNT_W`, default 8: width of `fire_count`.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset (low = in reset).
- `n1_vld` in 1 / `n1_rdy` out 1: neighbor 1 operand-vector handshake.
- `n2_vld` in 1 / `n2_rdy` out 1: neighbor 2 operand-vector handshake.
- `cfg_vld` in 1 / `cfg_rdy` out 1: config-word handshake.
- `rf_wen1`, `rf_wen2`, `rf_wen3` out 1: register file write enables for set 1, set 2 and the config register.
- `rf_wr_ack1`, `rf_wr_ack2`, `rf_wr_ack3` in 1: register file write acknowledges, each one cycle after its write.
- `rf_ren` out 1: register file read enable; also blocks register file writes while high.
- `rf_r_data_vld` in 1: register file read-valid.
- `fu_start` out 1: one-cycle FU launch pulse.
- `fu_done` in 1: FU completion pulse.
- `busy` out 1: high when state is not FILL.
- `fire_count` out `CNT_W`: number of completed FU operations; wraps.
- `timeout_err` out 1: sticky timeout flag.

## Operation
State flags:
- `ld1`, `ld2`, `ld3`: set 1, set 2 and config loaded.
- `pend1`, `pend2`, `pend3`: write issued, ack not yet seen.

FILL state:
- `nX_rdy` = state==FILL & !ldX & !pendX. `cfg_rdy` uses the same rule on `ld3`/`pend3`.
- `rf_wenX` = `vld` & `rdy` for that port, combinationally. Neighbor data is routed directly to the register file write data.
- A transfer sets `pendX`.
- `rf_wr_ackX` clears `pendX` and sets `ldX`.
- An ack arriving while `pendX`=0 is ignored.
- The three ports are independent. Any combination may transfer in the same cycle.
- When `ld1`&`ld2`&`ld3` and no `pend` flag is set, go to FIRE next cycle.

FIRE state (exactly 1 cycle):
- `rf_ren`=1 and `fu_start`=1.
- `fu_done` is ignored in this cycle.
- Next state is EXEC, and the timeout counter clears to 0.

EXEC state:
- `rf_ren`=1.
- `fu_done`=1: `fire_count`+1 (modulo 2^`CNT_W`), clear `ld1`/`ld2` and `ld3` (see Configuration), go to FILL.
- Otherwise the counter increments. When the counter equals `TIMEOUT_CYC` without `fu_done`: set `timeout_err`, clear all `ld` flags, go to FILL. `fire_count` is not incremented on a timeout.
- `fu_done` and the timeout in the same cycle: `fu_done` wins.

Assertions:
- `rf_r_data_vld` must equal `rf_ren` in FIRE and EXEC.

## Timing
Reset:
- Asserting `reset` low takes effect asynchronously, including mid-EXEC or with writes pending.
- While `reset`=0: state=FILL, all flags=0, counter=0, `fire_count`=0, `timeout_err`=0.
- While `reset`=0, all outputs are 0, including the `rdy` signals, which are gated by `reset`.
- A register file ack arriving after a reset is ignored because its `pend` flag is 0.

Latency:
- vld&rdy → `rf_wen` in the same cycle.
- Ack one cycle later → `ld` set.
- Last ack → FIRE on the next edge.
- Minimum FILL→FIRE is 2 cycles after the last handshake.
- FU completion → FILL on the next edge.
- Next `rdy` is high in the first FILL cycle.

Outputs:
- `fu_start` is Moore (decoded from state).
- `rdy`/`rf_wen` are combinational from state, flags and `vld`.
- `busy` = state!=FILL.

Write safety:
- No `rf_wen` is ever asserted while `rf_ren`=1.

## Configuration
- `REGFILE_SCHED_CFG_STICKY_EN` defined: `ld3` stays set after `fu_done`. The config word is reused, so later firings need only the two neighbor vectors. `ld3` is cleared only on timeout or reset.
- Not defined: `ld3` clears on every `fu_done`. Every firing requires a fresh config transfer.

## Test plan
- **Basic fire.** Stimulus: after reset, pulse `n1_vld`, `n2_vld`, `cfg_vld` together for 1 cycle; acks 1 cycle later; `fu_done` 3 cycles after `fu_start`. Required: all three `rf_wen` high in the same cycle, exactly one `fu_start`, `rf_ren` high for 4 cycles, `fire_count`=1, `n1_rdy` high again afterwards.
- **Staggered arrival.** Stimulus: n1 at cycle 0, cfg at cycle 5, n2 at cycle 10. Required: FIRE occurs on the edge after the n2 ack; each `rdy` stays low once its set is loaded.
- **Timeout.** Stimulus: `TIMEOUT_CYC`=4, `fu_done` never asserted. Required: `timeout_err`=1 after the 4th EXEC cycle, return to FILL, `fire_count` unchanged, `timeout_err` still 1 on the next successful fire.
- **Done/timeout tie.** Stimulus: `fu_done` asserted in the timeout cycle. Required: `fire_count` increments and `timeout_err` stays 0.
- **Reset mid-EXEC.** Stimulus: `reset` low during EXEC with `fire_count`=3. Required: all outputs 0 immediately; after release state=FILL, `fire_count`=0, and a late ack does not set `ld`.
- **Sticky config.** Stimulus: `fire_count` 255→0 wrap using `CNT_W`=8. Required with `REGFILE_SCHED_CFG_STICKY_EN`: the second firing needs only n1/n2 and `cfg_rdy` stays 0. Required without the macro: the second firing waits for `cfg_vld`.
